sccb_master: RTL

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_master.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_master.sv
// sccb_master: register-programmed, write-only SCCB master.
// A CONTROL write launches a 3-phase (slave address, register address, data)
// or 4-phase (adds a second data byte) frame on scl_out / sda / sda_oe.
// Each SCL period is four quarters of CLK_DIV clk cycles.
// Optional build macro SCCB_ACK_CHECK_EN: when defined, success_out is 1
// only if every ninth (ACK) bit was sampled low. When undefined, ACK bits
// are ignored and every completed frame reports success.
module sccb_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    input  logic       write,
    output logic       ready,
    output logic       success_out,
    output logic       scl_out,
    output logic       sda,
    output logic       sda_oe,
    input  logic       sda_in
);

    // Register map
    localparam logic [2:0] ADDR_CONTROL    = 3'd0;
    localparam logic [2:0] ADDR_SLAVE_ADDR = 3'd1;
    localparam logic [2:0] ADDR_SLAVE_REG  = 3'd2;
    localparam logic [2:0] ADDR_DATA_1     = 3'd3;
    localparam logic [2:0] ADDR_DATA_2     = 3'd4;

    // Last clk index inside one quarter
    localparam logic [9:0] Q_LAST = 10'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        ACK,
        STOP,
        DONE
    } state_t;

    // Programmable byte registers
    logic [7:0] slave_addr_q;
    logic [7:0] slave_reg_q;
    logic [7:0] data_1_q;
    logic [7:0] data_2_q;

    // Snapshot of the frame taken when a transaction is accepted
    logic [7:0] tx_q [4];
    logic       four_phase_q;

    // Sequencer state
    state_t     state_q,   state_d;
    logic [9:0] q_cnt_q,   q_cnt_d;     // clk within current quarter
    logic [1:0] quarter_q, quarter_d;   // quarter within bit (or STOP step)
    logic [2:0] bit_q,     bit_d;       // bit index, MSB first
    logic [1:0] phase_q,   phase_d;     // byte index within frame
    logic       launch_q,  launch_d;    // first START clk: acceptance, bus still idle
    logic       ack_ok_q,  ack_ok_d;    // all ACKs seen low so far
    logic       success_q;

    logic       q_end;
    logic       accept;
    logic       ack_bit;
    logic [1:0] last_phase;
    logic [7:0] cur_byte;

    assign q_end      = (q_cnt_q == Q_LAST);
    assign accept     = (state_q == IDLE) && write && (address == ADDR_CONTROL) && writedata[0];
    assign last_phase = four_phase_q ? 2'd3 : 2'd2;
    assign cur_byte   = tx_q[phase_q];

    assign ready       = (state_q == IDLE);
    assign success_out = success_q;

`ifdef SCCB_ACK_CHECK_EN
    // A high level on the ninth bit is a NACK
    assign ack_bit = sda_in;
`else
    // ACK level is a don't-care; the pad readback is intentionally left unused
    logic unused_sda_in;
    assign unused_sda_in = sda_in;
    assign ack_bit       = 1'b0;
`endif

    // Host-side byte registers: writable only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_addr_q <= '0;
            slave_reg_q  <= '0;
            data_1_q     <= '0;
            data_2_q     <= '0;
        end else if ((state_q == IDLE) && write) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values, matching real hardware.
            case (address)
                ADDR_SLAVE_ADDR: slave_addr_q <= writedata;
                ADDR_SLAVE_REG:  slave_reg_q  <= writedata;
                ADDR_DATA_1:     data_1_q     <= writedata;
                ADDR_DATA_2:     data_2_q     <= writedata;
                default:         ;
            endcase
        end
    end

    // Frame snapshot and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the snapshot is only four bytes, so it is cleared on reset
            // like any other register; large RAM-style arrays would not be.
            for (int i = 0; i < 4; i++) begin
                tx_q[i] <= '0;
            end
            four_phase_q <= 1'b0;
            success_q    <= 1'b0;
        end else begin
            if (accept) begin
                tx_q[0]      <= slave_addr_q;
                tx_q[1]      <= slave_reg_q;
                tx_q[2]      <= data_1_q;
                tx_q[3]      <= data_2_q;
                four_phase_q <= writedata[1];
            end
            if (state_q == DONE) begin
                success_q <= ack_ok_q;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            q_cnt_q   <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            launch_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_cnt_q   <= q_cnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            launch_q  <= launch_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

    // Next-state and bus output decode
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        q_cnt_d   = q_cnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        launch_d  = launch_q;
        ack_ok_d  = ack_ok_q;
        scl_out   = 1'b1;
        sda       = 1'b1;
        sda_oe    = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    launch_d  = 1'b1;
                    q_cnt_d   = '0;
                    quarter_d = '0;
                    bit_d     = 3'd7;
                    phase_d   = '0;
                    ack_ok_d  = 1'b1;
                end
            end

            START: begin
                // One acceptance clk with the bus idle, then SDA low for a
                // quarter while SCL stays high.
                sda = launch_q;
                if (launch_q) begin
                    launch_d = 1'b0;
                end else begin
                    q_cnt_d = q_end ? '0 : q_cnt_q + 10'd1;
                    if (q_end) begin
                        state_d   = BYTE;
                        quarter_d = '0;
                    end
                end
            end

            BYTE: begin
                scl_out = quarter_q[1];
                sda     = cur_byte[bit_q];
                q_cnt_d = q_end ? '0 : q_cnt_q + 10'd1;
                if (q_end) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end

            ACK: begin
                scl_out = quarter_q[1];
                sda_oe  = 1'b0;
                q_cnt_d = q_end ? '0 : q_cnt_q + 10'd1;
                // Sample the slave's answer on the first clk of Q3
                if ((quarter_q == 2'd3) && (q_cnt_q == '0) && ack_bit) begin
                    ack_ok_d = 1'b0;
                end
                if (q_end) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (phase_q == last_phase) begin
                            state_d = STOP;
                        end else begin
                            state_d = BYTE;
                            phase_d = phase_q + 2'd1;
                            bit_d   = 3'd7;
                        end
                    end
                end
            end

            STOP: begin
                // Step 0: SCL low, SDA low. Step 1: SCL high, SDA low.
                // SDA then rises in DONE and stays high through IDLE.
                scl_out = quarter_q[0];
                sda     = 1'b0;
                q_cnt_d = q_end ? '0 : q_cnt_q + 10'd1;
                if (q_end) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q[0]) begin
                        state_d   = DONE;
                        quarter_d = '0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
